// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: state and grant encodings shared by the two-master Wishbone arbiter.
package wshb_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ABORT = 2'd3} arb_state_t;
    typedef logic [1:0] gnt_t;
    localparam gnt_t GNT_NONE = 2'b00;
    localparam gnt_t GNT_M0   = 2'b01;
    localparam gnt_t GNT_M1   = 2'b10;
endpackage

// File: rtl/wshb_arb_watchdog.sv
// wshb_arb_watchdog: counts stalled strobe cycles and fires on the TIMEOUT-th one.
module wshb_arb_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic stb,
    input  logic resp,
    output logic fire
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    logic [W-1:0] cnt;
    logic stall;
    assign stall = active && stb && !resp;
    assign fire = stall && (cnt == LAST);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (!stall) cnt <= '0;
        else if (cnt != LAST) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/wshb_arbiter_2m.sv
// wshb_arbiter_2m: shares one Wishbone slave between two masters with a per-transfer watchdog.
// Define WSHB_ARB_FIXED_PRIO_EN to always give IDLE ties to m0 instead of round-robin.
module wshb_arbiter_2m
    import wshb_arb_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_ms,
    input  logic [3:0]       m0_sel,
    output logic [DAT_W-1:0] m0_dat_sm,
    output logic             m0_ack,
    output logic             m0_err,
    output logic             m0_rty,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_ms,
    input  logic [3:0]       m1_sel,
    output logic [DAT_W-1:0] m1_dat_sm,
    output logic             m1_ack,
    output logic             m1_err,
    output logic             m1_rty,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_ms,
    output logic [3:0]       s_sel,
    input  logic [DAT_W-1:0] s_dat_sm,
    input  logic             s_ack,
    input  logic             s_err,
    input  logic             s_rty,
    output logic [1:0]       gnt,
    output logic             wd_fired
);
    arb_state_t state, state_nx;
    logic own, own_nx, rel, tie_m1, cur_cyc, cur_stb, active, fwd, fire, resp;
    assign cur_cyc = own ? m1_cyc : m0_cyc;
    assign cur_stb = own ? m1_stb : m0_stb;
    assign active  = (state == GNT0 || state == GNT1) && cur_cyc;
    assign resp    = s_ack | s_err | s_rty;
    assign fwd     = active && !fire;
`ifdef WSHB_ARB_FIXED_PRIO_EN
    assign tie_m1 = 1'b0;
`else
    logic last;
    assign tie_m1 = !last;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) last <= 1'b1;
        else if (rel) last <= own;
    end
`endif
    always_comb begin
        state_nx = state;
        own_nx = own;
        rel = 1'b0;
        if (state == IDLE) begin
            if (m0_cyc || m1_cyc) begin
                own_nx = m1_cyc && (!m0_cyc || tie_m1);
                state_nx = own_nx ? GNT1 : GNT0;
            end
        end else if (!cur_cyc) begin
            rel = 1'b1;
            state_nx = IDLE;
        end else if (fire) begin
            state_nx = ABORT;
        end
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            own <= 1'b0;
        end else begin
            state <= state_nx;
            own <= own_nx;
        end
    end
    wshb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk(sys_clk), .rst_n(sys_rst_n), .active(active), .stb(cur_stb), .resp(resp), .fire(fire)
    );
    // the abort cycle itself already drops the slave bus
    assign s_cyc    = fwd;
    assign s_stb    = fwd && cur_stb;
    assign s_we     = fwd && (own ? m1_we : m0_we);
    assign s_adr    = fwd ? (own ? m1_adr : m0_adr) : '0;
    assign s_dat_ms = fwd ? (own ? m1_dat_ms : m0_dat_ms) : '0;
    assign s_sel    = fwd ? (own ? m1_sel : m0_sel) : '0;
    assign m0_ack    = fwd && !own && s_ack;
    assign m0_err    = !own && ((fwd && s_err) || fire);
    assign m0_rty    = fwd && !own && s_rty;
    assign m0_dat_sm = (fwd && !own) ? s_dat_sm : '0;
    assign m1_ack    = fwd && own && s_ack;
    assign m1_err    = own && ((fwd && s_err) || fire);
    assign m1_rty    = fwd && own && s_rty;
    assign m1_dat_sm = (fwd && own) ? s_dat_sm : '0;
    assign gnt      = (state == IDLE) ? GNT_NONE : own ? GNT_M1 : GNT_M0;
    assign wd_fired = fire;
endmodule

// File: tb/tb_wshb_arbiter_2m.sv
// tb_wshb_arbiter_2m: directed checks of grant order, bursts, watchdog abort and reset behaviour.
module tb_wshb_arbiter_2m;
    localparam int ADR_W = 32, DAT_W = 32, TIMEOUT = 8;
    logic sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [ADR_W-1:0] m0_adr, m1_adr, s_adr;
    logic [DAT_W-1:0] m0_dat_ms, m1_dat_ms, m0_dat_sm, m1_dat_sm, s_dat_ms, s_dat_sm;
    logic [3:0] m0_sel, m1_sel, s_sel;
    logic m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic s_cyc, s_stb, s_we, s_ack, s_err, s_rty, wd_fired;
    logic [1:0] gnt;
    logic ack_man = 1'b0, auto_ack = 1'b0;
    int n_chk = 0, n_fail = 0;

    always #5 sys_clk = ~sys_clk;
    // zero-wait slave: acks whichever granted master is strobing
    assign s_ack = ack_man | (auto_ack & ((gnt[0] & m0_stb) | (gnt[1] & m1_stb)));
    assign s_err = 1'b0;
    assign s_rty = 1'b0;

    wshb_arbiter_2m #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_ms(m0_dat_ms),
        .m0_sel(m0_sel), .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_ms(m1_dat_ms),
        .m1_sel(m1_sel), .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel),
        .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
        .gnt(gnt), .wd_fired(wd_fired)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_masters();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_ms = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_ms = '0; m1_sel = '0;
    endtask

    task automatic pulse_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_masters();
        s_dat_sm = 32'h1234_5678;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        n_chk++; if ({s_cyc, s_stb, s_we, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty, wd_fired} !== 10'b0) begin
            n_fail++; $display("FAIL rst_ctrl: got %b want 0", {s_cyc, s_stb, s_we, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty, wd_fired}); end
        n_chk++; if (m0_dat_sm !== 32'h0 || m1_dat_sm !== 32'h0) begin n_fail++; $display("FAIL rst_dat: got %h/%h want 0", m0_dat_sm, m1_dat_sm); end
        n_chk++; if (s_adr !== 32'h0) begin n_fail++; $display("FAIL rst_adr: got %h want 0", s_adr); end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_single_grant();
        s_dat_sm = '0;
        step(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
        @(negedge sys_clk);
        n_chk++; if (s_cyc !== 1'b0 || gnt !== 2'b00) begin n_fail++; $display("FAIL t1_c0: got cyc=%b gnt=%b want 0/00", s_cyc, gnt); end
        step();
        @(negedge sys_clk);
        n_chk++; if (s_cyc !== 1'b1 || s_stb !== 1'b1 || gnt !== 2'b01) begin n_fail++; $display("FAIL t1_c1: got cyc=%b stb=%b gnt=%b want 1/1/01", s_cyc, s_stb, gnt); end
        n_chk++; if (s_adr !== 32'h100 || m0_ack !== 1'b0) begin n_fail++; $display("FAIL t1_c1_adr: got adr=%h ack=%b want 100/0", s_adr, m0_ack); end
        step();
        step(); ack_man = 1;
        @(negedge sys_clk);
        n_chk++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin n_fail++; $display("FAIL t1_ack: got m0=%b m1=%b want 1/0", m0_ack, m1_ack); end
        step(); ack_man = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge sys_clk);
        n_chk++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL t1_drop: got s_cyc=%b want 0", s_cyc); end
        step();
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL t1_idle: got gnt=%b want 00", gnt); end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [4];
        int gaps [4];
        int n = 0, idle = 0, b0, b1;
        logic [1:0] prev = 2'b00;
        pulse_reset();
        auto_ack = 1;
        for (int r = 0; r < 2; r++) begin
            b0 = 0; b1 = 0;
            for (int c = 0; c < 40 && (b0 < 4 || b1 < 4); c++) begin
                step();
                m0_cyc = b0 < 4; m0_stb = b0 < 4; m1_cyc = b1 < 4; m1_stb = b1 < 4;
                @(negedge sys_clk);
                if (m0_ack) b0++;
                if (m1_ack) b1++;
                if (gnt == 2'b00) idle++;
                else if (gnt != prev && n < 4) begin order[n] = gnt; gaps[n] = idle; n++; idle = 0; end
                prev = gnt;
            end
            step(); m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        end
        auto_ack = 0;
        n_chk++; if (n != 4) begin n_fail++; $display("FAIL rr_count: got %0d grants want 4", n); end
        else begin
            n_chk++; if (order[0] !== 2'b01) begin n_fail++; $display("FAIL rr_g0: got %b want 01", order[0]); end
            n_chk++; if (order[1] !== 2'b10) begin n_fail++; $display("FAIL rr_g1: got %b want 10", order[1]); end
            n_chk++; if (order[2] !== 2'b01) begin n_fail++; $display("FAIL rr_g2: got %b want 01", order[2]); end
            n_chk++; if (order[3] !== 2'b10) begin n_fail++; $display("FAIL rr_g3: got %b want 10", order[3]); end
            for (int i = 1; i < 4; i++) begin
                n_chk++; if (gaps[i] != 1) begin n_fail++; $display("FAIL rr_gap%0d: got %0d idle cycles want 1", i, gaps[i]); end
            end
        end
    endtask

    task automatic test_burst_hold();
        int b1 = 0, bad = 0;
        bit seen = 0;
        auto_ack = 1; m0_adr = 32'h1000; m1_adr = 32'h2000;
        for (int c = 0; c < 40 && b1 < 16; c++) begin
            step();
            m1_cyc = 1; m1_stb = 1;
            if (c == 2) begin m0_cyc = 1; m0_stb = 1; end
            @(negedge sys_clk);
            if (gnt == 2'b10) seen = 1; else if (seen) bad++;
            if (seen && (s_adr !== 32'h2000 || m0_ack !== 1'b0)) bad++;
            if (m1_ack) b1++;
        end
        n_chk++; if (b1 != 16 || !seen) begin n_fail++; $display("FAIL burst_beats: got %0d beats seen=%0d want 16/1", b1, seen); end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL burst_hold: got %0d bad cycles want 0", bad); end
        step(); m1_cyc = 0; m1_stb = 0;
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b10 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL burst_end: got gnt=%b cyc=%b want 10/0", gnt, s_cyc); end
        step();
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b00 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL burst_dead: got gnt=%b cyc=%b want 00/0", gnt, s_cyc); end
        step();
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b01 || s_adr !== 32'h1000 || m0_ack !== 1'b1) begin
            n_fail++; $display("FAIL burst_next: got gnt=%b adr=%h ack=%b want 01/1000/1", gnt, s_adr, m0_ack); end
        step(); m0_cyc = 0; m0_stb = 0;
        step(); auto_ack = 0;
    endtask

    task automatic test_watchdog();
        int bad = 0;
        step(); m1_cyc = 1; m1_stb = 1;
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL wd_c0: got gnt=%b want 00", gnt); end
        for (int k = 1; k < 8; k++) begin
            step();
            if (k == 2) begin m0_cyc = 1; m0_stb = 1; end
            @(negedge sys_clk);
            if (s_cyc !== 1'b1 || m1_err !== 1'b0 || wd_fired !== 1'b0) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL wd_early: got %0d bad stall cycles want 0", bad); end
        step();
        @(negedge sys_clk);
        n_chk++; if (m1_err !== 1'b1 || wd_fired !== 1'b1) begin n_fail++; $display("FAIL wd_fire: got err=%b fired=%b want 1/1", m1_err, wd_fired); end
        n_chk++; if ({s_cyc, s_stb, m0_err} !== 3'b000) begin n_fail++; $display("FAIL wd_fire_bus: got cyc/stb/m0err=%b want 000", {s_cyc, s_stb, m0_err}); end
        step(); ack_man = 1;
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b10 || {s_cyc, wd_fired, m1_ack, m1_err, m0_ack} !== 5'b0) begin
            n_fail++; $display("FAIL wd_abort: got gnt=%b flags=%b want 10/00000", gnt, {s_cyc, wd_fired, m1_ack, m1_err, m0_ack}); end
        step(); ack_man = 0; m1_cyc = 0; m1_stb = 0;
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b10 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL wd_release: got gnt=%b cyc=%b want 10/0", gnt, s_cyc); end
        step();
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL wd_idle: got gnt=%b want 00", gnt); end
        step();
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b01 || s_cyc !== 1'b1) begin n_fail++; $display("FAIL wd_m0: got gnt=%b cyc=%b want 01/1", gnt, s_cyc); end
        step(); m0_cyc = 0; m0_stb = 0;
        step();
    endtask

    task automatic test_idle_response();
        step(); ack_man = 1; s_dat_sm = 32'hDEAD_BEEF;
        @(negedge sys_clk);
        n_chk++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got %b/%b want 0/0", m0_ack, m1_ack); end
        n_chk++; if (m0_dat_sm !== 32'h0 || m1_dat_sm !== 32'h0) begin n_fail++; $display("FAIL idle_dat: got %h/%h want 0/0", m0_dat_sm, m1_dat_sm); end
        step(); ack_man = 0;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h3000; m0_sel = 4'hF; m1_adr = 32'h4000;
        step(); ack_man = 1;
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b01 || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            n_fail++; $display("FAIL rd_ack: got gnt=%b ack=%b/%b want 01/1/0", gnt, m0_ack, m1_ack); end
        n_chk++; if (m0_dat_sm !== 32'hDEAD_BEEF || m1_dat_sm !== 32'h0) begin
            n_fail++; $display("FAIL rd_dat: got %h/%h want deadbeef/0", m0_dat_sm, m1_dat_sm); end
        n_chk++; if (s_adr !== 32'h3000 || s_sel !== 4'hF || s_we !== 1'b0) begin
            n_fail++; $display("FAIL rd_req: got adr=%h sel=%h we=%b want 3000/f/0", s_adr, s_sel, s_we); end
        step(); ack_man = 0; m0_cyc = 0; m0_stb = 0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        auto_ack = 1;
        step(); m0_cyc = 1; m0_stb = 1;
        step();
        step();
        #2 sys_rst_n = 1'b0;
        #1;
        n_chk++; if ({s_cyc, s_stb, m0_ack} !== 3'b000 || gnt !== 2'b00) begin
            n_fail++; $display("FAIL arst: got cyc/stb/ack=%b gnt=%b want 000/00", {s_cyc, s_stb, m0_ack}, gnt); end
        m0_cyc = 0; m0_stb = 0;
        step();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL arst_idle: got gnt=%b want 00", gnt); end
        step();
        @(negedge sys_clk);
        n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL arst_rr: got gnt=%b want 01", gnt); end
        step(); idle_masters(); auto_ack = 0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_burst_hold();
        test_watchdog();
        test_idle_response();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
